// File: rtl/regfile_wb_arbiter_pkg.sv
// regfile_wb_arbiter_pkg: shared widths, FSM encoding and defaults for the writeback arbiter
package regfile_wb_arbiter_pkg;
  localparam int XLEN = 64;
  localparam int REG_ADDR_W = 5;
  localparam int NUM_REGS = 1 << REG_ADDR_W;
  localparam int STARVE_LIMIT_DEF = 4;
  typedef logic [REG_ADDR_W-1:0] reg_addr_t;
  typedef logic [XLEN-1:0] xlen_t;
  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_WAIT = 2'd1;
  localparam state_t ST_FORCE = 2'd2;
endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// regfile_wb_arbiter_if: writeback requests, scoreboard lookup and register-file write port
interface regfile_wb_arbiter_if;
  import regfile_wb_arbiter_pkg::*;
  logic a_valid;
  reg_addr_t a_rd;
  xlen_t a_data;
  logic b_valid;
  reg_addr_t b_rd;
  xlen_t b_data;
  logic b_ready;
  logic issue_valid;
  reg_addr_t issue_rd;
  reg_addr_t rs1;
  reg_addr_t rs2;
  logic busy_rs1;
  logic busy_rs2;
  logic wb_we;
  reg_addr_t wb_rd;
  xlen_t wb_data;
  logic stall_req;
  logic err;
  modport master (
    output a_valid, a_rd, a_data, b_valid, b_rd, b_data, issue_valid, issue_rd, rs1, rs2,
    input b_ready, busy_rs1, busy_rs2, wb_we, wb_rd, wb_data, stall_req, err
  );
  modport slave (
    input a_valid, a_rd, a_data, b_valid, b_rd, b_data, issue_valid, issue_rd, rs1, rs2,
    output b_ready, busy_rs1, busy_rs2, wb_we, wb_rd, wb_data, stall_req, err
  );
endinterface

// File: rtl/regfile_wb_arbiter_scoreboard.sv
// reg_busy_scoreboard: tracks registers awaiting long-latency writeback and flags protocol errors
module reg_busy_scoreboard
  import regfile_wb_arbiter_pkg::*;
(
  input  logic      clk,
  input  logic      reset,
  input  logic      issue_valid,
  input  reg_addr_t issue_rd,
  input  logic      b_hs,
  input  reg_addr_t b_rd,
  input  reg_addr_t rs1,
  input  reg_addr_t rs2,
  input  logic      force_err,
  output logic      busy_rs1,
  output logic      busy_rs2,
  output logic      err
);
  logic [NUM_REGS-1:0] busy_q, busy_d, set_v, clr_v;
  logic err_q, err_d;
  always_comb begin
    set_v = '0;
    clr_v = '0;
    set_v[issue_rd] = issue_valid;
    clr_v[b_rd] = b_hs;
    busy_d = busy_q & ~clr_v | set_v;
    busy_d[0] = 1'b0;
    err_d = err_q || force_err
      || (issue_valid && busy_q[issue_rd] && !(b_hs && b_rd == issue_rd))
      || (b_hs && b_rd != '0 && !busy_q[b_rd]);
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      busy_q <= '0;
      err_q <= 1'b0;
    end else begin
      busy_q <= busy_d;
      err_q <= err_d;
    end
  end
  assign busy_rs1 = busy_q[rs1];
  assign busy_rs2 = busy_q[rs2];
  assign err = err_q;
endmodule

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: merges pipeline and long-latency writebacks onto one register-file write port
module regfile_wb_arbiter
  import regfile_wb_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
  input logic clk,
  input logic reset,
  regfile_wb_arbiter_if.slave bus
);
  state_t state_q, state_d;
  logic [3:0] cnt_q, cnt_d, cnt_inc;
  logic force_st, grant_a, b_hs, denied;
  logic wb_we_q, wb_we_d, stall_q, stall_d;
  reg_addr_t wb_rd_q, wb_rd_d;
  xlen_t wb_data_q, wb_data_d;
  assign force_st = state_q == ST_FORCE;
  assign grant_a = bus.a_valid && !force_st;
  assign bus.b_ready = reset && (force_st || !bus.a_valid);
  assign b_hs = bus.b_valid && bus.b_ready;
  assign denied = bus.b_valid && grant_a;
  always_comb begin
    cnt_inc = cnt_q >= 4'(STARVE_LIMIT) ? cnt_q : cnt_q + 4'd1;
    cnt_d = denied ? cnt_inc : 4'd0;
    state_d = !denied ? ST_IDLE : cnt_inc >= 4'(STARVE_LIMIT) ? ST_FORCE : ST_WAIT;
    stall_d = state_d == ST_FORCE;
    wb_we_d = grant_a ? |bus.a_rd : b_hs && |bus.b_rd;
    wb_rd_d = grant_a ? bus.a_rd : b_hs ? bus.b_rd : wb_rd_q;
    wb_data_d = grant_a ? bus.a_data : b_hs ? bus.b_data : wb_data_q;
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      cnt_q <= 4'd0;
      stall_q <= 1'b0;
      wb_we_q <= 1'b0;
      wb_rd_q <= '0;
      wb_data_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      stall_q <= stall_d;
      wb_we_q <= wb_we_d;
      wb_rd_q <= wb_rd_d;
      wb_data_q <= wb_data_d;
    end
  end
  assign bus.wb_we = wb_we_q;
  assign bus.wb_rd = wb_rd_q;
  assign bus.wb_data = wb_data_q;
  assign bus.stall_req = stall_q;
  reg_busy_scoreboard u_sb (
    .clk        (clk),
    .reset      (reset),
    .issue_valid(bus.issue_valid),
    .issue_rd   (bus.issue_rd),
    .b_hs       (b_hs),
    .b_rd       (bus.b_rd),
    .rs1        (bus.rs1),
    .rs2        (bus.rs2),
    .force_err  (force_st && bus.a_valid),
    .busy_rs1   (bus.busy_rs1),
    .busy_rs2   (bus.busy_rs2),
    .err        (bus.err)
  );
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb_regfile_wb_arbiter: directed checks plus a cycle model of the writeback arbiter
module tb_regfile_wb_arbiter;
  localparam int LIM = 4;
  logic clk = 1'b0;
  logic reset;
  int n_cmp = 0;
  int n_bad = 0;
  regfile_wb_arbiter_if bus();
  regfile_wb_arbiter #(.STARVE_LIMIT(LIM)) dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  bit m_on = 0;
  bit m_we, m_force, m_err;
  logic [4:0] m_rd;
  logic [63:0] m_data;
  int m_deny;
  bit [31:0] m_busy;
  function automatic void chk(string nm, logic [63:0] got, logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", nm, got, exp, $time);
    end
  endfunction
  always @(posedge clk) begin
    bit a_ok, b_ok;
    if (!reset) begin
      m_on = 1; m_we = 0; m_rd = 0; m_data = 0; m_force = 0; m_deny = 0; m_err = 0; m_busy = 0;
    end else if (m_on) begin
      a_ok = bus.a_valid && !m_force;
      b_ok = bus.b_valid && !a_ok;
      if (m_force && bus.a_valid) m_err = 1;
      if (bus.issue_valid && m_busy[bus.issue_rd] && !(b_ok && bus.b_rd == bus.issue_rd)) m_err = 1;
      if (b_ok && bus.b_rd != 0 && !m_busy[bus.b_rd]) m_err = 1;
      m_we = 0;
      if (a_ok) begin m_we = bus.a_rd != 0; m_rd = bus.a_rd; m_data = bus.a_data; end
      else if (b_ok) begin m_we = bus.b_rd != 0; m_rd = bus.b_rd; m_data = bus.b_data; end
      if (b_ok) m_busy[bus.b_rd] = 0;
      if (bus.issue_valid) m_busy[bus.issue_rd] = 1;
      m_busy[0] = 0;
      m_deny = (bus.b_valid && a_ok) ? (m_deny < LIM ? m_deny + 1 : LIM) : 0;
      m_force = m_deny == LIM;
    end
  end
  always @(negedge clk) begin
    if (m_on) begin
      chk("m_wb_we", 64'(bus.wb_we), 64'(m_we));
      chk("m_wb_rd", 64'(bus.wb_rd), 64'(m_rd));
      chk("m_wb_data", bus.wb_data, m_data);
      chk("m_stall", 64'(bus.stall_req), 64'(m_force));
      chk("m_err", 64'(bus.err), 64'(m_err));
      chk("m_b_ready", 64'(bus.b_ready), 64'(reset && (m_force || !bus.a_valid)));
      chk("m_busy_rs1", 64'(bus.busy_rs1), 64'(m_busy[bus.rs1]));
      chk("m_busy_rs2", 64'(bus.busy_rs2), 64'(m_busy[bus.rs2]));
    end
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic settle();
    #1;
  endtask
  task automatic idle();
    bus.a_valid = 0; bus.b_valid = 0; bus.issue_valid = 0;
  endtask
  task automatic issue(input logic [4:0] rd);
    bus.issue_valid = 1; bus.issue_rd = rd;
    tick();
    bus.issue_valid = 0;
  endtask
  task automatic starve(input logic [4:0] brd, input logic [63:0] bd);
    bus.b_valid = 1; bus.b_rd = brd; bus.b_data = bd;
    for (int i = 0; i < LIM; i++) begin
      bus.a_valid = 1; bus.a_rd = 5'd1; bus.a_data = 64'h100 + 64'(i);
      tick();
      chk("starve_stall", 64'(bus.stall_req), 64'(i == LIM - 1));
      chk("starve_a_wb_rd", 64'(bus.wb_rd), 64'd1);
    end
  endtask
  initial begin
    reset = 0;
    idle();
    bus.a_rd = 0; bus.a_data = 0; bus.b_rd = 0; bus.b_data = 0;
    bus.issue_rd = 0; bus.rs1 = 0; bus.rs2 = 0;
    tick(); tick();
    chk("rst_wb_we", 64'(bus.wb_we), 64'd0);
    chk("rst_wb_rd", 64'(bus.wb_rd), 64'd0);
    chk("rst_wb_data", bus.wb_data, 64'd0);
    chk("rst_stall", 64'(bus.stall_req), 64'd0);
    chk("rst_err", 64'(bus.err), 64'd0);
    chk("rst_b_ready", 64'(bus.b_ready), 64'd0);
    reset = 1;
    bus.a_valid = 1; bus.a_rd = 5; bus.a_data = 64'h55;
    bus.issue_valid = 1; bus.issue_rd = 2;
    tick();
    idle();
    chk("a_wb_we", 64'(bus.wb_we), 64'd1);
    chk("a_wb_rd", 64'(bus.wb_rd), 64'd5);
    chk("a_wb_data", bus.wb_data, 64'h55);
    bus.rs2 = 2;
    settle();
    chk("a_b_ready", 64'(bus.b_ready), 64'd1);
    chk("busy2_set", 64'(bus.busy_rs2), 64'd1);
    starve(5'd2, 64'hBB);
    bus.a_valid = 0;
    settle();
    chk("force_b_ready", 64'(bus.b_ready), 64'd1);
    tick();
    bus.b_valid = 0;
    chk("force_wb_we", 64'(bus.wb_we), 64'd1);
    chk("force_wb_rd", 64'(bus.wb_rd), 64'd2);
    chk("force_wb_data", bus.wb_data, 64'hBB);
    chk("force_stall_off", 64'(bus.stall_req), 64'd0);
    chk("force_err", 64'(bus.err), 64'd0);
    chk("busy2_clr", 64'(bus.busy_rs2), 64'd0);
    issue(5'd7);
    bus.rs1 = 7;
    settle();
    chk("busy7_set", 64'(bus.busy_rs1), 64'd1);
    bus.b_valid = 1; bus.b_rd = 7; bus.b_data = 64'h77;
    settle();
    chk("busy7_hs", 64'(bus.busy_rs1), 64'd1);
    tick();
    bus.b_valid = 0;
    chk("busy7_clr", 64'(bus.busy_rs1), 64'd0);
    chk("b7_wb_rd", 64'(bus.wb_rd), 64'd7);
    bus.b_valid = 1; bus.b_rd = 0; bus.b_data = 64'hFF;
    settle();
    chk("x0_b_ready", 64'(bus.b_ready), 64'd1);
    tick();
    bus.b_valid = 0;
    chk("x0_wb_we", 64'(bus.wb_we), 64'd0);
    chk("x0_err", 64'(bus.err), 64'd0);
    issue(5'd3);
    bus.issue_valid = 1; bus.issue_rd = 3;
    bus.b_valid = 1; bus.b_rd = 3; bus.b_data = 64'h33;
    tick();
    idle();
    bus.rs1 = 3;
    settle();
    chk("same_busy3", 64'(bus.busy_rs1), 64'd1);
    chk("same_err", 64'(bus.err), 64'd0);
    chk("same_wb_data", bus.wb_data, 64'h33);
    issue(5'd10);
    starve(5'd10, 64'hAA);
    bus.a_rd = 12; bus.a_data = 64'hDEAD;
    tick();
    idle();
    chk("fa_wb_rd", 64'(bus.wb_rd), 64'd10);
    chk("fa_wb_data", bus.wb_data, 64'hAA);
    chk("fa_err", 64'(bus.err), 64'd1);
    chk("fa_stall", 64'(bus.stall_req), 64'd0);
    issue(5'd9);
    bus.rs1 = 9;
    starve(5'd9, 64'h99);
    bus.a_valid = 0;
    reset = 0;
    settle();
    chk("rf_busy9_pre", 64'(bus.busy_rs1), 64'd1);
    chk("rf_b_ready_rst", 64'(bus.b_ready), 64'd0);
    tick();
    reset = 1;
    chk("rf_stall", 64'(bus.stall_req), 64'd0);
    chk("rf_wb_we", 64'(bus.wb_we), 64'd0);
    chk("rf_err", 64'(bus.err), 64'd0);
    chk("rf_busy9", 64'(bus.busy_rs1), 64'd0);
    bus.a_valid = 1;
    settle();
    chk("rf_idle_b_ready", 64'(bus.b_ready), 64'd0);
    tick();
    idle();
    tick();
    issue(5'd3);
    issue(5'd3);
    bus.rs1 = 3;
    settle();
    chk("dup_err", 64'(bus.err), 64'd1);
    chk("dup_busy3", 64'(bus.busy_rs1), 64'd1);
    reset = 0;
    tick();
    reset = 1;
    chk("rst2_err", 64'(bus.err), 64'd0);
    bus.b_valid = 1; bus.b_rd = 4; bus.b_data = 64'h44;
    tick();
    idle();
    chk("orphan_err", 64'(bus.err), 64'd1);
    chk("orphan_wb_rd", 64'(bus.wb_rd), 64'd4);
    repeat (3) tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/regfile_wb_arbiter.md
REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

Interface
REQ-001 SHALL have parameter STARVE_LIMIT, default 4: consecutive cycles port B may be denied before the pipeline is forced to stall; legal range 1..15.
REQ-002 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-low reset; 0 at a rising clk edge resets all state.
REQ-004 SHALL have ports a_valid/a_rd/a_data  input  1/5/64  pipeline writeback request; no ready, so it is never back-pressured.
REQ-005 SHALL have ports b_valid/b_rd/b_data  input  1/5/64  long-latency unit writeback request.
REQ-006 SHALL have port b_ready  output  1  B accepted when b_valid and b_ready are both 1 at a clk edge.
REQ-007 SHALL have ports issue_valid/issue_rd  input  1/5  long-latency op issued; marks issue_rd busy.
REQ-008 SHALL have ports rs1/rs2  input  5/5  and busy_rs1/busy_rs2  output  1/1  scoreboard lookup for the hazard unit.
REQ-009 SHALL have ports wb_we/wb_rd/wb_data  output  1/5/64  registered register-file write port.
REQ-010 SHALL have port stall_req  output  1  registered; pipeline must hold a_valid=0 while it is 1.
REQ-011 SHALL have port err  output  1  sticky protocol-error flag.

Function
REQ-012 SHALL grant A whenever a_valid=1 and state is not FORCE; otherwise B when b_valid=1.
REQ-013 SHALL drive b_ready = (state==FORCE) or not a_valid, combinationally.
REQ-014 SHALL register the granted request to wb_we/wb_rd/wb_data one cycle after the grant edge; with no grant, wb_we=0 and wb_rd/wb_data hold.
REQ-015 SHALL force wb_we=0 when the granted rd is 0; a B handshake to x0 still completes.
REQ-016 SHALL implement FSM IDLE/WAIT/FORCE: IDLE->WAIT when b_valid and a_valid (B denied); WAIT->IDLE on B handshake or b_valid dropping; WAIT->FORCE when denial count reaches STARVE_LIMIT; FORCE->IDLE unconditionally after one cycle.
REQ-017 SHALL count consecutive B denials in a 4-bit counter, cleared on B handshake or entry to IDLE, saturating at STARVE_LIMIT.
REQ-018 SHALL assert stall_req exactly while state==FORCE.
REQ-019 SHALL ignore a_valid in FORCE (no write) and set err.
REQ-020 SHALL keep a 32-bit busy vector: set busy[issue_rd] on issue_valid, clear busy[b_rd] on B handshake; set wins when both target the same rd in one cycle; busy[0] always 0.
REQ-021 SHALL drive busy_rs1/busy_rs2 combinationally from the current busy vector; the clear takes effect the cycle after the handshake.
REQ-022 SHALL set err on issue_valid to an rd already busy (busy bit stays set) and on a B handshake to a non-busy nonzero rd.

Reset
REQ-023 SHALL, on reset=0 at a clk edge, set state=IDLE, counter=0, busy=0, wb_we=0, wb_rd=0, wb_data=0, stall_req=0, err=0.
REQ-024 SHALL force b_ready=0 while reset=0; requests in flight are discarded, not replayed.

Structure
REQ-025 SHALL place XLEN=64, REG_ADDR_W=5, the FSM state encoding and the default STARVE_LIMIT in a shared package.
REQ-026 SHALL implement the busy vector, lookups and err checks as sub-module reg_busy_scoreboard; arbitration and FSM stay in the top module.

Verification
REQ-027 SHALL check: A alone, rd=5, data=0x55 -> next cycle wb_we=1, wb_rd=5, wb_data=0x55; b_ready=1.
REQ-028 SHALL check: A and B both valid for 4 cycles, STARVE_LIMIT=4 -> B denied 4 cycles, stall_req=1 in cycle 5, B written in cycle 6, stall_req=0 in cycle 6.
REQ-029 SHALL check: issue rd=7, then B handshake rd=7 -> busy_rs1(rs1=7)=1 until the cycle after the handshake, then 0.
REQ-030 SHALL check: B handshake rd=0, data=0xFF -> wb_we=0, handshake completes, err=0.
REQ-031 SHALL check: issue rd=3 and B handshake rd=3 in the same cycle, with 3 already busy -> busy[3] remains 1, err=0.
REQ-032 SHALL check: reset=0 in FORCE with busy[9]=1 -> next cycle state=IDLE, stall_req=0, busy_rs1(rs1=9)=0, wb_we=0.
